// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline sequencing
//               controller: FSM state encoding, ResultSrc encodings, the x0
//               register index and the load-use hazard helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } pipe_state_t;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    localparam logic [4:0] REG_X0 = 5'd0;

    // A load in Execute whose destination feeds a Decode source operand.
    // x0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic loadUseHazard(
        input logic [1:0] resultSrcE,
        input logic [4:0] rdE,
        input logic [4:0] rs1D,
        input logic [4:0] rs2D
    );
        return (resultSrcE == RESULT_MEM) && (rdE != REG_X0) &&
               ((rdE == rs1D) || (rdE == rs2D));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Hazard inputs and stall/flush outputs of the pipeline
//               sequencing controller.
//   master : datapath side - drives hazard sources, receives stall/flush
//   slave  : controller side - receives hazard sources, drives stall/flush
//   Signals: Rs1D, Rs2D, RdE, ResultSrcE, PCSrcE, MemReqM, MemReadyM (to ctrl)
//            StallF/D/E/M, FlushD/E/W, MemErr                    (from ctrl)
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;
    logic [4:0] Rs1D;
    logic [4:0] Rs2D;
    logic [4:0] RdE;
    logic [1:0] ResultSrcE;
    logic       PCSrcE;
    logic       MemReqM;
    logic       MemReadyM;
    logic       StallF;
    logic       StallD;
    logic       StallE;
    logic       StallM;
    logic       FlushD;
    logic       FlushE;
    logic       FlushW;
    logic       MemErr;

    modport master (
        output Rs1D, Rs2D, RdE, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr
    );

    modport slave (
        input  Rs1D, Rs2D, RdE, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr
    );
endinterface
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_timer
// Description : Counts consecutive data-memory wait cycles. Synchronous clear
//               has priority over enable; the count saturates at all-ones.
//               o_timeout flags that the count has reached MEM_TIMEOUT.
//   clk, rst  : clock, synchronous active-high reset
//   i_clr     : clear the count to zero
//   i_en      : increment the count
//   o_timeout : count == MEM_TIMEOUT
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    localparam int WAIT_W     = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);
    logic [WAIT_W-1:0] r_waitCnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_waitCnt <= '0;
        end else if (i_en && (r_waitCnt != '1)) begin
            r_waitCnt <= r_waitCnt + 1'b1;
        end
    end

    assign o_timeout = (r_waitCnt == WAIT_W'(MEM_TIMEOUT));
endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline sequencing controller for the 5-stage RV32I core.
//               Produces per-stage stall/flush from load-use hazards, taken
//               branches resolved in Execute and data-memory wait states,
//               with a sticky memory-timeout error that halts the pipeline.
//   clk, rst : core clock, synchronous active-high reset
//   pif      : pipe_ctrl_if.slave (hazard sources in, stall/flush out)
//   StallCnt, FlushCnt : performance counters (PIPE_CTRL_PERF_EN only)
// Optional    : define PIPE_CTRL_PERF_EN to add the performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_ctrl_if.slave           pif
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] StallCnt,
    output logic [CNT_WIDTH-1:0] FlushCnt
`endif
);
    pipe_state_t r_state;
    logic        r_memErr;

    logic w_lwStall;
    logic w_memStall;
    logic w_timeout;
    logic w_timerEn;
    logic w_timerClr;
    logic w_stallF, w_stallD, w_stallE, w_stallM;
    logic w_flushD, w_flushE, w_flushW;

    assign w_lwStall  = loadUseHazard(pif.ResultSrcE, pif.RdE, pif.Rs1D, pif.Rs2D);
    assign w_memStall = pif.MemReqM && !pif.MemReadyM;

    // The first wait cycle is counted while still in RUN, so the count
    // equals the number of wait cycles already spent.
    assign w_timerEn  = ((r_state == RUN) && w_memStall) ||
                        ((r_state == MEM_WAIT) && !pif.MemReadyM);
    assign w_timerClr = (r_state == MEM_WAIT) && pif.MemReadyM;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_memWaitTimer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_timerClr),
        .i_en      (w_timerEn),
        .o_timeout (w_timeout)
    );

    // Output decode. Memory stalls freeze F..M and bubble W; otherwise a
    // taken branch squashes D and E and overrides any load-use stall.
    always_comb begin
        w_stallF = 1'b0;
        w_stallD = 1'b0;
        w_stallE = 1'b0;
        w_stallM = 1'b0;
        w_flushD = 1'b0;
        w_flushE = 1'b0;
        w_flushW = 1'b0;
        if (rst) begin
            w_flushD = 1'b1;
            w_flushE = 1'b1;
            w_flushW = 1'b1;
        end else if ((r_state == HALT) ||
                     ((r_state == RUN) && w_memStall) ||
                     ((r_state == MEM_WAIT) && !pif.MemReadyM)) begin
            w_stallF = 1'b1;
            w_stallD = 1'b1;
            w_stallE = 1'b1;
            w_stallM = 1'b1;
            w_flushW = 1'b1;
        end else if (pif.PCSrcE) begin
            w_flushD = 1'b1;
            w_flushE = 1'b1;
        end else if (w_lwStall) begin
            w_stallF = 1'b1;
            w_stallD = 1'b1;
            w_flushE = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_memErr <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_memStall) begin
                        r_state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (pif.MemReadyM) begin
                        r_state <= RUN;
                    end else if (w_timeout) begin
                        r_state  <= HALT;
                        r_memErr <= 1'b1;
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= HALT;
                end
            endcase
        end
    end

    assign pif.StallF = w_stallF;
    assign pif.StallD = w_stallD;
    assign pif.StallE = w_stallE;
    assign pif.StallM = w_stallM;
    assign pif.FlushD = w_flushD;
    assign pif.FlushE = w_flushE;
    assign pif.FlushW = w_flushW;
    assign pif.MemErr = r_memErr;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_WIDTH-1:0] r_stallCnt;
    logic [CNT_WIDTH-1:0] r_flushCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (w_stallF && (r_state != HALT) && (r_stallCnt != '1)) begin
                r_stallCnt <= r_stallCnt + 1'b1;
            end
            if ((w_flushD || w_flushE) && (r_flushCnt != '1)) begin
                r_flushCnt <= r_flushCnt + 1'b1;
            end
        end
    end

    assign StallCnt = r_stallCnt;
    assign FlushCnt = r_flushCnt;
`endif
endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage RV32I core. It generates the per-stage stall and flush signals that the F/D/E/M/W pipeline registers and the PC register consume. Sources are load-use hazards, taken branches/jumps resolved in Execute, and wait states from a multi-cycle data memory. It sits beside the forwarding hazard unit: that unit selects operands, this block freezes or bubbles stages. It owns a small FSM plus a memory-timeout counter.

## Interface
Parameters:
- MEM_TIMEOUT, 16, maximum consecutive data-memory wait cycles before a fatal timeout.
- CNT_WIDTH, 32, width of the performance counters (used only with PIPE_CTRL_PERF_EN).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- Rs1D, Rs2D  in  5 each  source registers of the instruction in Decode.
- RdE  in  5  destination register of the instruction in Execute.
- ResultSrcE  in  2  Execute result select; RESULT_MEM (2'b01) marks a load.
- PCSrcE  in  1  taken branch or jump resolved in Execute.
- MemReqM  in  1  Memory stage performs a load or store this cycle.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register (StallF also holds the PC).
- FlushD, FlushE, FlushW  out  1 each  load a bubble (all controls zero) into the D, E or W register.
- MemErr  out  1  sticky memory-timeout flag.

## Operation
- States: RUN, MEM_WAIT, HALT. Encoding comes from the package.
- Definitions:
  - lwStall = ResultSrcE==RESULT_MEM && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
  - memStall = MemReqM && !MemReadyM.
- RUN:
  - memStall: StallF=StallD=StallE=StallM=1, FlushW=1. lwStall and PCSrcE are ignored this cycle. Next state MEM_WAIT, wait_cnt=1.
  - Otherwise, if PCSrcE: FlushD=FlushE=1 and lwStall is suppressed, because the Decode instruction is discarded.
  - Otherwise, if lwStall: StallF=StallD=1, FlushE=1.
  - Otherwise all outputs are 0.
- MEM_WAIT:
  - If MemReadyM: no memory stalls; PCSrcE and lwStall are evaluated exactly as in RUN; next state RUN.
  - Otherwise: same outputs as memStall in RUN, and wait_cnt increments.
  - If wait_cnt==MEM_TIMEOUT and MemReadyM==0: next state HALT, MemErr set.
- HALT: StallF, StallD, StallE and StallM held at 1, FlushW=1, MemErr=1. Only rst exits HALT.
- x0 never creates a load-use hazard.
- PCSrcE and lwStall are mutually exclusive by construction. If both are asserted, PCSrcE wins.
- Mid-operation reset behaves identically to power-on reset.

## Timing
- All stall and flush outputs are combinational from the current state and current inputs, so they take effect at the next rising edge.
- State, wait_cnt and MemErr are registered.
- Reset values, applied while rst=1 and in the first cycle after it:
  - state RUN, wait_cnt 0, MemErr 0.
  - While rst=1: FlushD=FlushE=FlushW=1, all stalls 0.
- Load-use costs exactly one bubble cycle; a taken branch costs two squashed instructions.
- A memory access with N wait cycles (MemReadyM low for N cycles) stalls F–M for exactly N cycles and inserts N W-bubbles. Zero-wait memory (MemReadyM tied high) never leaves RUN.
- wait_cnt is $clog2(MEM_TIMEOUT+1) bits wide and saturates. It clears on entry to RUN.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - Adds outputs StallCnt [CNT_WIDTH-1:0] and FlushCnt [CNT_WIDTH-1:0], both reset to 0 and saturating at all-ones.
  - StallCnt increments on every cycle with StallF=1, excluding HALT.
  - FlushCnt increments on every cycle with FlushD=1 or FlushE=1, excluding reset.
- Not defined: these ports and registers are absent, and behaviour is otherwise identical.

## Structure
- Shared package pipe_ctrl_pkg:
  - pipe_state_t enum (RUN, MEM_WAIT, HALT).
  - ResultSrc encodings (RESULT_ALU, RESULT_MEM, RESULT_PC4).
  - REG_X0 constant.
- One sub-module, mem_wait_timer:
  - Contents: the wait_cnt counter with clear, enable and saturate, plus a timeout compare.
  - Parameterised by MEM_TIMEOUT.
- Hazard detection and output decode stay in pipe_ctrl.

## Test plan
- Load-use: RdE=5, ResultSrcE=01, Rs1D=5, MemReadyM=1 -> StallF=StallD=FlushE=1 for one cycle, then all 0.
- x0 load: RdE=0, Rs2D=0, ResultSrcE=01 -> no stall, no flush.
- Taken branch with lwStall also asserted (Rs1D=RdE=3, ResultSrcE=01, PCSrcE=1) -> FlushD=FlushE=1, StallF=0.
- Memory wait: MemReqM=1, MemReadyM low 3 cycles then high -> StallF..StallM and FlushW high exactly 3 cycles; state back to RUN on cycle 4.
- Branch during wait: PCSrcE=1 while in MEM_WAIT -> no flush until the MemReadyM cycle, then FlushD=FlushE=1 in that cycle.
- Timeout with MEM_TIMEOUT=4: MemReadyM held low -> HALT and MemErr=1 after 4 wait cycles; rst pulse -> RUN, MemErr=0, and (with PIPE_CTRL_PERF_EN) StallCnt=0.
